// File: rtl/demux_8_2outputs.sv
// demux_8_2outputs: registered 1-to-2 demultiplexer with a small valid/ready FIFO per output
// Ports:
//   clk, rst_n (async active-low), flush (sync clear of both FIFOs)
//   in_data/op/in_valid/in_ready : producer side, op selects FIFO 1 (0) or FIFO 2 (1)
//   out1_data/out1_valid/out1_ready, out2_*  : consumer sides, head of each FIFO
//   out1_count/out2_count : completed pop counters, live only with DEMUX_STATS_EN defined
// Parameters: WIDTH data width, DEPTH entries per FIFO (power of two, >= 2)
module demux_8_2outputs #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [15:0]      out1_count,
  output logic [15:0]      out2_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic [AW-1:0]    r_wp [2];
  logic [AW-1:0]    r_rp [2];
  logic [AW:0]      r_occ [2];
  logic [AW:0]      w_occ_nxt [2];
  logic [1:0]       r_vld, w_push, w_pop, w_ordy;
  assign w_ordy = {out2_ready, out1_ready};
  // Looks only at registered occupancy: a full FIFO refuses a push even while it drains.
  assign in_ready = !flush && (r_occ[op] < FULL);
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      w_push[f]    = in_valid && in_ready && (op == 1'(f));
      w_pop[f]     = !flush && r_vld[f] && w_ordy[f];
      w_occ_nxt[f] = (w_push[f] && !w_pop[f]) ? r_occ[f] + 1'b1 :
                     (w_pop[f] && !w_push[f]) ? r_occ[f] - 1'b1 : r_occ[f];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 2; f++) begin
        r_occ[f] <= '0;
        r_wp[f]  <= '0;
        r_rp[f]  <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[f][i] <= '0;
      end
      r_vld <= '0;
    end else if (flush) begin
      for (int f = 0; f < 2; f++) begin
        r_occ[f] <= '0;
        r_wp[f]  <= '0;
        r_rp[f]  <= '0;
      end
      r_vld <= '0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (w_push[f]) begin
          r_mem[f][r_wp[f]] <= in_data;
          r_wp[f]           <= r_wp[f] + 1'b1;
        end
        if (w_pop[f]) r_rp[f] <= r_rp[f] + 1'b1;
        r_occ[f] <= w_occ_nxt[f];
        r_vld[f] <= w_occ_nxt[f] != '0;
      end
    end
  end
  assign out1_valid = r_vld[0];
  assign out2_valid = r_vld[1];
  assign out1_data  = r_mem[0][r_rp[0]];
  assign out2_data  = r_mem[1][r_rp[1]];
`ifdef DEMUX_STATS_EN
  logic [15:0] r_cnt1, r_cnt2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else begin
      if (w_pop[0]) r_cnt1 <= r_cnt1 + 1'b1;
      if (w_pop[1]) r_cnt2 <= r_cnt2 + 1'b1;
    end
  end
  assign out1_count = r_cnt1;
  assign out2_count = r_cnt2;
`else
  assign out1_count = '0;
  assign out2_count = '0;
`endif
endmodule

// File: tb/tb_demux_8_2outputs.sv
// tb_demux_8_2outputs: randomized and directed checks of demux_8_2outputs against a queue model
module tb_demux_8_2outputs;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, flush = 0, op = 0, in_valid = 0, in_ready;
  logic [7:0] in_data = 0, out1_data, out2_data;
  logic out1_valid, out1_ready = 0, out2_valid, out2_ready = 0;
  logic [15:0] out1_count, out2_count;
  logic [7:0] q0[$], q1[$];
  logic [15:0] c1 = 0, c2 = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  demux_8_2outputs #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out1_count(out1_count), .out2_count(out2_count));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_cnt(input logic [15:0] c);
`ifdef DEMUX_STATS_EN
    return c;
`else
    return 16'h0;
`endif
  endfunction
  task automatic cyc(output bit acc);
    bit er, p, p0, p1;
    #2;
    er = !flush && ((op ? q1.size() : q0.size()) < DEPTH);
    check("in_ready", in_ready, er);
    check("o1_valid", out1_valid, q0.size() != 0);
    check("o2_valid", out2_valid, q1.size() != 0);
    if (q0.size() != 0) check("o1_data", out1_data, q0[0]);
    if (q1.size() != 0) check("o2_data", out2_data, q1[0]);
    check("o1_count", out1_count, exp_cnt(c1));
    check("o2_count", out2_count, exp_cnt(c2));
    p  = in_valid && er;
    p0 = q0.size() != 0 && out1_ready;
    p1 = q1.size() != 0 && out2_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) begin void'(q0.pop_front()); c1++; end
      if (p1) begin void'(q1.pop_front()); c2++; end
      if (p) begin
        if (op) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
    acc = p;
  endtask
  task automatic idle(input int n);
    bit a;
    in_valid = 0;
    for (int i = 0; i < n; i++) cyc(a);
  endtask
  task automatic send(input logic o, input logic [7:0] d);
    bit done = 0;
    int n = 0;
    in_valid = 1; op = o; in_data = d;
    while (!done && n < 20) begin cyc(done); n++; end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic reset_now();
    rst_n = 0;
    #1;
    check("rst_o1_valid", out1_valid, 0);
    check("rst_o2_valid", out2_valid, 0);
    check("rst_o1_data", out1_data, 0);
    check("rst_o2_data", out2_data, 0);
    check("rst_o1_count", out1_count, 0);
    check("rst_o2_count", out2_count, 0);
    q0.delete(); q1.delete(); c1 = 0; c2 = 0;
    in_valid = 0; flush = 0;
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit a;
    #1;
    check("rst_in_ready", in_ready, 1);
    reset_now();
    // route and hold
    send(0, 8'hA5);
    send(1, 8'h5A);
    idle(10);
    check("hold_o1", out1_data, 8'hA5);
    check("hold_o2", out2_data, 8'h5A);
    out1_ready = 1; out2_ready = 1;
    idle(2);
    out1_ready = 0; out2_ready = 0;
    // fill to full, then other side still accepts
    send(0, 8'hFF);
    send(0, 8'h00);
    in_valid = 1; op = 0; in_data = 8'h77;
    cyc(a);
    check("full_refused", a, 0);
    send(1, 8'h12);
    out1_ready = 1;
    idle(3);
    out1_ready = 0; out2_ready = 1;
    idle(2);
    out2_ready = 0;
    // full with same-cycle pop
    send(0, 8'hDE);
    send(0, 8'hBE);
    out1_ready = 1;
    in_valid = 1; op = 0; in_data = 8'h34;
    cyc(a);
    check("full_pop_no_push", a, 0);
    cyc(a);
    check("full_pop_next_push", a, 1);
    in_valid = 0;
    idle(3);
    // streaming
    out2_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; op = i[0]; in_data = 8'(i);
      cyc(a);
      check("stream_acc", a, 1);
    end
    idle(2);
    // flush with data present and a push offered
    out1_ready = 0; out2_ready = 0;
    send(0, 8'h11);
    send(1, 8'h22);
    flush = 1; in_valid = 1; op = 0; in_data = 8'h99;
    cyc(a);
    flush = 0; in_valid = 0;
    check("flush_o1_valid", out1_valid, 0);
    check("flush_o2_valid", out2_valid, 0);
    idle(2);
    // counters from a clean reset: 3 pops on output1, 5 on output2
    @(negedge clk);
    reset_now();
    out1_ready = 1; out2_ready = 1;
    for (int i = 0; i < 3; i++) send(0, 8'(i + 1));
    for (int i = 0; i < 5; i++) send(1, 8'(i + 8));
    idle(2);
    check("cnt1", out1_count, exp_cnt(16'd3));
    check("cnt2", out2_count, exp_cnt(16'd5));
    // random traffic with occasional flush and a mid-stream asynchronous reset
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      op = 1'($urandom);
      in_data = 8'($urandom);
      out1_ready = ($urandom_range(3) != 0);
      out2_ready = ($urandom_range(3) == 0);
      flush = ($urandom_range(31) == 0);
      if (i == 300) begin
        #2;
        reset_now();
      end else cyc(a);
    end
    flush = 0;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_8_2outputs.md
# demux_8_2outputs

Registered 1-to-2 demultiplexer with per-output buffering. It is the data-path counterpart of the 8-bit 2-input mux: one producer stream is steered to one of two consumers by a select bit. It sits between a pipeline stage and two downstream consumers, for example ALU results routed to a writeback path or to a forwarding path. Each output has a small FIFO with valid/ready handshaking, so a stalled consumer never blocks the other.

## Interface
Parameters:
- `WIDTH`, 8: data width of input and both outputs.
- `DEPTH`, 2: entries per output FIFO; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of both FIFOs.
- `in_data`  in  WIDTH  producer data.
- `op`  in  1  destination select: 0 → output1, 1 → output2.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  block accepts data this cycle.
- `out1_data`  out  WIDTH  head of FIFO 1.
- `out1_valid`  out  1  FIFO 1 non-empty.
- `out1_ready`  in  1  consumer 1 takes the head entry.
- `out2_data`, `out2_valid`, `out2_ready`: same as above, for FIFO 2.
- `out1_count`, `out2_count`  out  16  completed-transfer counters (see Configuration).

## Operation
- **Push.** An input transfer occurs when `in_valid && in_ready`. `in_data` is written to the FIFO chosen by `op` at that FIFO's write pointer.
- **in_ready rule.**
  - `in_ready = !flush && (occupancy[op] < DEPTH)`.
  - It depends only on `op`, `flush` and registered occupancy. There is no combinational path from `out*_ready`.
  - A full FIFO therefore refuses a push even if it is draining in the same cycle.
- **Pop.** An output transfer occurs when `outN_valid && outN_ready`. The read pointer advances.
- **Occupancy.** Each FIFO has a registered occupancy of width log2(DEPTH)+1.
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, with both pointers advancing.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- **Output signals.**
  - `outN_valid = (occupancy != 0)`, driven from a register.
  - `outN_data` is the entry at the read pointer.
  - While `outN_valid` is held and not accepted, `outN_data` must not change.
- **Independence.** Only the FIFO selected by `op` is affected by a push. The other FIFO keeps draining unaffected.
- **Flush.** When `flush` is 1, both occupancies and all pointers go to 0 on the next edge. Flush has priority over a push or pop in the same cycle, and data in that cycle is discarded.
- **Reset.** An asynchronous reset mid-operation discards all contents immediately. Reset values:
  - occupancies 0, pointers 0;
  - `out1_valid` = `out2_valid` = 0;
  - `out1_data` = `out2_data` = 0 (storage cleared);
  - `in_ready` = 1 once `rst_n` is high and `flush` is 0;
  - counters 0.

## Timing
- **Latency.** Data accepted at edge N appears on `outN_valid`/`outN_data` after edge N, i.e. one cycle. There is no same-cycle bypass.
- **Throughput.** One push per cycle when the target FIFO is not full. Each output can pop once per cycle, in parallel with the other output.
- **Full FIFO, push and pop in the same cycle.** The pop completes. The producer's transfer does not occur and it must hold the data. `in_ready` rises the following cycle.
- **Changing `op` while `in_valid` is held and not accepted.** This is permitted, and `in_ready` is re-evaluated for the new destination in the same cycle.

## Configuration
- **Macro:** `DEMUX_STATS_EN`.
- **Defined.**
  - `out1_count`/`out2_count` increment by 1 on each output-side transfer of the respective FIFO.
  - Width is 16 bits, wrapping from 0xFFFF to 0x0000.
  - Counters are cleared by reset only, not by `flush`.
- **Not defined.** The counter ports still exist but are tied to 16'h0000, and no counter registers are synthesized.

## Test plan
- **Route and hold.** After reset, push A5 (op=0) then 5A (op=1) with both readies low. Required response:
  - `out1_valid`=1 with `out1_data`=A5;
  - `out2_valid`=1 with `out2_data`=5A;
  - both hold unchanged for 10 cycles.
- **Fill to full.** Push FF, 00 to output1 with `out1_ready`=0. Required response:
  - `in_ready`=0 while op=0;
  - `in_ready`=1 while op=1;
  - push 12 to output2 succeeds;
  - raise `out1_ready` → output1 delivers FF then 00 in order.
- **Full with same-cycle pop.** FIFO1 full (DE, BE); in the same cycle present 34 with op=0 and `out1_ready`=1. Required response:
  - DE pops;
  - 34 is not accepted that cycle;
  - 34 is accepted the next cycle;
  - drain order is BE, 34.
- **Streaming.** Stream 16 bytes (0x00–0x0F) alternating op, with both readies high. Required response:
  - `in_ready` stays 1 throughout;
  - each output sees its own 8 bytes in order, one cycle after acceptance.
- **Flush and reset.**
  - Flush with both FIFOs holding data and a push offered in the same cycle → next cycle both valids 0, and the pushed data is dropped.
  - Assert `rst_n`=0 mid-stream, asynchronously between edges → valids drop to 0 immediately.
- **Counters.** With `DEMUX_STATS_EN`, 3 output1 pops and 5 output2 pops give `out1_count`=3 and `out2_count`=5. Without the macro, both read 0.
